fp_mul_scheduler: RTL

FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

---
 rtl/fp_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/fp_mul_scheduler.sv | 78 +++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared state encoding and default parameters for the FP multiplier scheduler.
package fp_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam int SIZE_DEF = 32;
   localparam int N_REQ_DEF = 4;
   localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, priority starting just after the last grant.
module rr_arbiter #(
   parameter int N_REQ = fp_pkg::N_REQ_DEF,
   localparam int IW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);
   always_comb begin
      logic [IW-1:0] k;
      k = '0;
      idx = '0;
      // walk from farthest to nearest so the nearest valid requester wins
      for (int i = N_REQ; i >= 1; i--) begin
         k = IW'((int'(last) + i) % N_REQ);
         if (req[k]) idx = k;
      end
      any = |req;
      grant = any ? N_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler: serialises N_REQ requesters onto one FP multiplier with
// round-robin grant, operand hold, done/timeout capture and response handshake.
module fp_mul_scheduler
   import fp_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int N_REQ = N_REQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   localparam int IW = $clog2(N_REQ),
   localparam int CW = $clog2(TIMEOUT + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [N_REQ-1:0]      i_req_valid,
   input  logic [N_REQ*SIZE-1:0] i_req_a,
   input  logic [N_REQ*SIZE-1:0] i_req_b,
   output logic [N_REQ-1:0]      o_req_ready,
   output logic                  o_mul_start,
   output logic [SIZE-1:0]       o_mul_a,
   output logic [SIZE-1:0]       o_mul_b,
   input  logic [SIZE-1:0]       i_mul_result,
   input  logic                  i_mul_done,
   output logic                  o_rsp_valid,
   output logic [IW-1:0]         o_rsp_id,
   output logic [SIZE-1:0]       o_rsp_result,
   output logic                  o_rsp_err,
   input  logic                  i_rsp_ready,
   output logic                  o_busy
);
   state_t           state, state_n;
   logic [IW-1:0]    last_grant, gnt_idx;
   logic [N_REQ-1:0] gnt;
   logic             any_req, tmo;
   logic [CW-1:0]    cnt;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req(i_req_valid), .last(last_grant), .grant(gnt), .idx(gnt_idx), .any(any_req)
   );

   // counter holds the number of completed WAIT cycles, so this is the last allowed one
   assign tmo = cnt == CW'(TIMEOUT - 1);

   always_comb begin
      state_n = (state == IDLE)  ? (any_req ? ISSUE : IDLE) :
                (state == ISSUE) ? WAIT :
                (state == WAIT)  ? ((i_mul_done || tmo) ? RESP : WAIT) :
                (i_rsp_ready ? IDLE : RESP);
      o_req_ready = (state == IDLE && i_rst_n) ? gnt : '0;
      o_mul_start = state == ISSUE;
      o_rsp_valid = state == RESP;
      o_busy = state != IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state <= IDLE;
         last_grant <= IW'(N_REQ - 1);
         cnt <= '0;
         o_mul_a <= '0;
         o_mul_b <= '0;
         o_rsp_id <= '0;
         o_rsp_result <= '0;
         o_rsp_err <= '0;
      end else begin
         state <= state_n;
         cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
         if (state == IDLE && any_req) begin
            o_mul_a <= i_req_a[int'(gnt_idx)*SIZE +: SIZE];
            o_mul_b <= i_req_b[int'(gnt_idx)*SIZE +: SIZE];
            o_rsp_id <= gnt_idx;
         end
         if (state == WAIT && (i_mul_done || tmo)) begin
            o_rsp_result <= i_mul_done ? i_mul_result : '0;
            o_rsp_err <= !i_mul_done;
         end
         if (state == RESP && i_rsp_ready) last_grant <= o_rsp_id;
      end
endmodule
